// File: rtl/uart_parser_pkg.sv
// Shared definitions for the UART matrix parser.
// Holds the FSM state encoding, the err_code values, the ASCII byte constants
// and the byte classification helpers used by the parser and its accumulator.
package uart_parser_pkg;

  // FSM state encoding
  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_GET_ROWS = 3'd1;
  localparam logic [2:0] S_GET_COLS = 3'd2;
  localparam logic [2:0] S_GET_ELEM = 3'd3;
  localparam logic [2:0] S_DONE     = 3'd4;
  localparam logic [2:0] S_ERROR    = 3'd5;

  // err_code values
  localparam logic [2:0] ERR_NONE     = 3'd0;
  localparam logic [2:0] ERR_BAD_DIM  = 3'd1;
  localparam logic [2:0] ERR_BAD_CHAR = 3'd2;
  localparam logic [2:0] ERR_OVERFLOW = 3'd3;
  localparam logic [2:0] ERR_TIMEOUT  = 3'd4;

  // ASCII bytes of interest
  localparam logic [7:0] ASCII_0     = 8'h30;
  localparam logic [7:0] ASCII_9     = 8'h39;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_COMMA = 8'h2C;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;

  function automatic logic is_digit(input logic [7:0] b);
    return (b >= ASCII_0) && (b <= ASCII_9);
  endfunction

  function automatic logic is_sep(input logic [7:0] b);
    return (b == ASCII_SPACE) || (b == ASCII_COMMA) ||
           (b == ASCII_CR)    || (b == ASCII_LF);
  endfunction

  // Numeric value of a digit byte; meaningless for non-digits.
  function automatic logic [3:0] digit_val(input logic [7:0] b);
    return 4'(b - ASCII_0);
  endfunction

endpackage

// File: rtl/dec_accum.sv
// Decimal accumulator step: next_acc = (clear ? 0 : acc) * 10 + digit.
// Ports: acc (current value), digit (0..9), clear (start a new token),
//        next_acc (updated value), ovf (next_acc exceeds 2^ELEM_W-1).
// The accumulator is 4 bits wider than an element so that any legal value
// times ten plus nine still fits without wrapping.
module dec_accum #(
  parameter int unsigned ELEM_W = 8
) (
  input  logic [ELEM_W+3:0] acc,
  input  logic [3:0]        digit,
  input  logic              clear,
  output logic [ELEM_W+3:0] next_acc,
  output logic              ovf
);

  localparam int unsigned AW = ELEM_W + 4;
  localparam logic [AW-1:0] ELEM_MAX = {4'b0000, {ELEM_W{1'b1}}};

  logic [AW-1:0] base;

  always_comb begin
    base     = clear ? '0 : acc;
    next_acc = (base * AW'(10)) + AW'(digit);
    ovf      = next_acc > ELEM_MAX;
  end

endmodule

// File: rtl/uart_matrix_parser.sv
// Byte-stream to matrix parser sitting between the UART receiver and the
// matrix storage/compute units. Accepts "<rows><cols><elements...>" with
// single-digit dimensions and either multi-digit decimal tokens or, in
// compact mode, one element per digit.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   rx_data, rx_ready        received byte and its one-cycle strobe
//   parser_start             level; rising edge begins a parse
//   parser_abort             pulse; back to idle without an error
//   compact_mode             sampled on the start edge
//   rows, cols               parsed dimensions
//   matrix_flat              packed row-major matrix, zero padded
//   elem_count               elements stored so far
//   data_valid               one-cycle completion pulse
//   parser_busy              parse in progress
//   parse_error, err_code    error flag and cause
module uart_matrix_parser
  import uart_parser_pkg::*;
#(
  parameter int unsigned MAX_DIM     = 5,
  parameter int unsigned ELEM_W      = 8,
  parameter int unsigned TIMEOUT_CYC = 50_000_000,
  localparam int unsigned DW = $clog2(MAX_DIM + 1),
  localparam int unsigned CW = $clog2(MAX_DIM * MAX_DIM + 1)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [7:0]                          rx_data,
  input  logic                                rx_ready,
  input  logic                                parser_start,
  input  logic                                parser_abort,
  input  logic                                compact_mode,
  output logic [DW-1:0]                       rows,
  output logic [DW-1:0]                       cols,
  output logic [MAX_DIM*MAX_DIM*ELEM_W-1:0]   matrix_flat,
  output logic [CW-1:0]                       elem_count,
  output logic                                data_valid,
  output logic                                parser_busy,
  output logic                                parse_error,
  output logic [2:0]                          err_code
);

  localparam int unsigned NE = MAX_DIM * MAX_DIM;
  localparam int unsigned AW = ELEM_W + 4;

  logic [2:0]        state, state_n;
  logic              start_d;
  logic              compact;
  logic [DW-1:0]     row_idx, col_idx;
  logic [AW-1:0]     acc, next_acc;
  logic              have_digit;
  logic              ovf;
  logic              timeout_hit;

  logic              start_edge, in_get, b_dig, b_sep, dim_ok, last_elem, col_wrap;
  logic [3:0]        b_val;
  logic [CW-1:0]     wr_idx;

  logic              go_clear, set_rows, set_cols, acc_upd, acc_clr, wr_en, err_set;
  logic [ELEM_W-1:0] wr_val;
  logic [2:0]        err_val;

  // Byte classification and index helpers
  always_comb begin
    start_edge = parser_start & ~start_d;
    in_get     = (state == S_GET_ROWS) || (state == S_GET_COLS) || (state == S_GET_ELEM);
    b_dig      = is_digit(rx_data);
    b_sep      = is_sep(rx_data);
    b_val      = digit_val(rx_data);
    dim_ok     = (b_val != 4'd0) && (32'(b_val) <= MAX_DIM);
    col_wrap   = (col_idx == cols - DW'(1));
    last_elem  = col_wrap && (row_idx == rows - DW'(1));
    wr_idx     = (CW'(row_idx) * CW'(MAX_DIM)) + CW'(col_idx);
  end

  dec_accum #(.ELEM_W(ELEM_W)) u_dec_accum (
    .acc      (acc),
    .digit    (b_val),
    .clear    (~have_digit),
    .next_acc (next_acc),
    .ovf      (ovf)
  );

  // Inactivity timer: counts quiet cycles in the GET states only
  generate
    if (TIMEOUT_CYC > 0) begin : g_timeout
      localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
      logic [TW-1:0] to_cnt;

      always_ff @(posedge clk) begin
        if (rst || !in_get || rx_ready) begin
          to_cnt <= '0;
        end else begin
          to_cnt <= to_cnt + TW'(1);
        end
      end

      // Fires on the cycle that would make the quiet count reach TIMEOUT_CYC
      assign timeout_hit = in_get && (to_cnt == TW'(TIMEOUT_CYC - 1));
    end else begin : g_no_timeout
      assign timeout_hit = 1'b0;
    end
  endgenerate

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state and datapath control
  always_comb begin
    state_n  = state;
    go_clear = 1'b0;
    set_rows = 1'b0;
    set_cols = 1'b0;
    acc_upd  = 1'b0;
    acc_clr  = 1'b0;
    wr_en    = 1'b0;
    wr_val   = '0;
    err_set  = 1'b0;
    err_val  = ERR_NONE;
    case (state)
      S_IDLE: begin
        if (start_edge) begin
          state_n  = S_GET_ROWS;
          go_clear = 1'b1;
        end
      end
      S_GET_ROWS, S_GET_COLS: begin
        if (parser_abort) begin
          state_n = S_IDLE;
        end else if (timeout_hit) begin
          err_set = 1'b1;
          err_val = ERR_TIMEOUT;
        end else if (rx_ready && !b_sep) begin
          if (!b_dig) begin
            err_set = 1'b1;
            err_val = ERR_BAD_CHAR;
          end else if (!dim_ok) begin
            err_set = 1'b1;
            err_val = ERR_BAD_DIM;
          end else if (state == S_GET_ROWS) begin
            set_rows = 1'b1;
            state_n  = S_GET_COLS;
          end else begin
            set_cols = 1'b1;
            state_n  = S_GET_ELEM;
          end
        end
      end
      S_GET_ELEM: begin
        if (parser_abort) begin
          state_n = S_IDLE;
        end else if (timeout_hit) begin
          err_set = 1'b1;
          err_val = ERR_TIMEOUT;
        end else if (rx_ready) begin
          if (b_dig && compact) begin
            wr_en  = 1'b1;
            wr_val = ELEM_W'(b_val);
          end else if (b_dig) begin
            if (ovf) begin
              err_set = 1'b1;
              err_val = ERR_OVERFLOW;
            end else begin
              acc_upd = 1'b1;
            end
          end else if (b_sep) begin
            // Only the first separator after a token commits it
            if (!compact && have_digit) begin
              wr_en   = 1'b1;
              wr_val  = acc[ELEM_W-1:0];
              acc_clr = 1'b1;
            end
          end else begin
            err_set = 1'b1;
            err_val = ERR_BAD_CHAR;
          end
          if (wr_en && last_elem) begin
            state_n = S_DONE;
          end
        end
      end
      S_DONE, S_ERROR: begin
        if (parser_abort || !parser_start) begin
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
    if (err_set) begin
      state_n = S_ERROR;
    end
  end

  // Datapath and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      start_d     <= 1'b0;
      compact     <= 1'b0;
      row_idx     <= '0;
      col_idx     <= '0;
      acc         <= '0;
      have_digit  <= 1'b0;
      rows        <= '0;
      cols        <= '0;
      matrix_flat <= '0;
      elem_count  <= '0;
      data_valid  <= 1'b0;
      parser_busy <= 1'b0;
      parse_error <= 1'b0;
      err_code    <= ERR_NONE;
    end else begin
      start_d     <= parser_start;
      data_valid  <= (state_n == S_DONE) && (state != S_DONE);
      parser_busy <= (state_n == S_GET_ROWS) || (state_n == S_GET_COLS) ||
                     (state_n == S_GET_ELEM);
      parse_error <= (state_n == S_ERROR);

      if (go_clear) begin
        compact     <= compact_mode;
        row_idx     <= '0;
        col_idx     <= '0;
        rows        <= '0;
        cols        <= '0;
        matrix_flat <= '0;
        elem_count  <= '0;
        err_code    <= ERR_NONE;
      end

      if (set_rows) rows <= DW'(b_val);
      if (set_cols) cols <= DW'(b_val);
      if (err_set)  err_code <= err_val;

      if (go_clear || acc_clr) begin
        acc        <= '0;
        have_digit <= 1'b0;
      end else if (acc_upd) begin
        acc        <= next_acc;
        have_digit <= 1'b1;
      end

      if (wr_en) begin
        for (int unsigned k = 0; k < NE; k++) begin
          if (wr_idx == CW'(k)) begin
            matrix_flat[k*ELEM_W +: ELEM_W] <= wr_val;
          end
        end
        elem_count <= elem_count + CW'(1);
        // Row-major advance
        if (col_wrap) begin
          col_idx <= '0;
          row_idx <= row_idx + DW'(1);
        end else begin
          col_idx <= col_idx + DW'(1);
        end
      end
    end
  end

endmodule
